// File: rtl/prime_sieve_pkg.sv
// prime_sieve_pkg
// Shared types and constants for the prime sieve marking engine.
//   sieve_state_t : controller states, also exported on the engine's debug port
//   FIRST_PRIME   : first base examined by every sieve run
package prime_sieve_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        EVAL  = 3'd2,
        MARK  = 3'd3,
        DONE  = 3'd4
    } sieve_state_t;

    localparam int FIRST_PRIME = 2;

endpackage

// File: rtl/prime_sieve_stepper.sv
// prime_sieve_stepper
// Multiple generator for one base prime. On load it starts at p*p with a
// stride of p, or 2*p for odd bases when PRIME_SIEVE_ODD_STEP_EN is defined.
// Each advance moves to the next multiple.
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   load          : start a new base (m = p*p, step = stride of p)
//   advance       : step m to the next multiple
//   p             : current base prime
//   max_value     : inclusive upper bound of the sieve
//   square_over   : p*p > max_value, so this base has nothing to mark
//   mark_addr     : RAM address of the current multiple
//   last_write    : current multiple is the last one that fits under max_value
module prime_sieve_stepper #(
    parameter int N_WIDTH    = 10,
    parameter int SQRT_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    input  logic [SQRT_WIDTH-1:0] p,
    input  logic [N_WIDTH-1:0]    max_value,
    output logic                  square_over,
    output logic [N_WIDTH-1:0]    mark_addr,
    output logic                  last_write
);
    import prime_sieve_pkg::*;

    // Compare width large enough for both the full square and the bound.
    localparam int CMP_W = (2 * SQRT_WIDTH > N_WIDTH + 1) ? 2 * SQRT_WIDTH : N_WIDTH + 1;
`ifdef PRIME_SIEVE_ODD_STEP_EN
    localparam int STEP_W = SQRT_WIDTH + 1;
`else
    localparam int STEP_W = SQRT_WIDTH;
`endif

    logic [2*SQRT_WIDTH-1:0] p_sq;
    logic [CMP_W-1:0]        p_sq_w;
    logic [CMP_W-1:0]        max_w;
    logic [STEP_W-1:0]       step_init;
    logic [STEP_W-1:0]       step_q;
    logic [N_WIDTH:0]        m_q;
    logic [N_WIDTH:0]        m_next;

    // Full-width square: a large base can never wrap below max and mark junk.
    assign p_sq        = {{SQRT_WIDTH{1'b0}}, p} * {{SQRT_WIDTH{1'b0}}, p};
    assign p_sq_w      = CMP_W'(p_sq);
    assign max_w       = CMP_W'(max_value);
    assign square_over = p_sq_w > max_w;

`ifdef PRIME_SIEVE_ODD_STEP_EN
    // Even multiples of an odd base are already marked by base 2.
    assign step_init = (p == SQRT_WIDTH'(FIRST_PRIME)) ? {1'b0, p} : {p, 1'b0};
`else
    assign step_init = p;
`endif

    // One extra bit on m: the stride past the top address is caught here
    // rather than wrapping to a low index.
    assign m_next     = m_q + (N_WIDTH + 1)'(step_q);
    assign last_write = m_next > {1'b0, max_value};
    assign mark_addr  = m_q[N_WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_q    <= '0;
            step_q <= '0;
        end else if (load) begin
            m_q    <= (N_WIDTH + 1)'(p_sq);
            step_q <= step_init;
        end else if (advance) begin
            m_q    <= m_next;
        end
    end

endmodule

// File: rtl/prime_sieve_engine.sv
// prime_sieve_engine
// Sieve-of-Eratosthenes marker. It walks base candidates 2..sqrt_bound and
// reads each one back from an external 1-bit RAM, skipping bases that are
// already composite. For each prime base it writes composite flags from p*p
// up to max_prime.
// Optional build macro: PRIME_SIEVE_ODD_STEP_EN (odd bases mark odd multiples only).
// Handshake: start is sampled only in IDLE; busy is high in every other state;
// done pulses for one cycle (with busy) on completion; abort in any non-IDLE
// state returns to IDLE next cycle without done, and beats start in IDLE.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   start, abort : run request / synchronous cancel
//   max_prime    : inclusive upper bound, latched on start
//   sqrt_bound   : last base to process, latched on start
//   busy, done   : status
//   ram_addr     : shared read/write address
//   ram_rden     : read strobe, ram_rdata valid the following cycle
//   ram_rdata    : 1 = entry already composite
//   ram_wren     : write strobe, data implicitly 1
//   dbg_state    : current controller state (sieve_state_t encoding)
module prime_sieve_engine #(
    parameter int N_WIDTH    = 10,
    parameter int SQRT_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [N_WIDTH-1:0]    max_prime,
    input  logic [SQRT_WIDTH-1:0] sqrt_bound,
    output logic                  busy,
    output logic                  done,
    output logic [N_WIDTH-1:0]    ram_addr,
    output logic                  ram_rden,
    input  logic                  ram_rdata,
    output logic                  ram_wren,
    output logic [2:0]            dbg_state
);
    import prime_sieve_pkg::*;

    sieve_state_t          state, next_state;
    logic [SQRT_WIDTH-1:0] p_q;
    logic [N_WIDTH-1:0]    max_q;
    logic [SQRT_WIDTH-1:0] sqrt_q;

    logic                  load, advance, next_base;
    logic                  square_over, last_write;
    logic [N_WIDTH-1:0]    mark_addr;
    logic                  accept_start;

    assign accept_start = (state == IDLE) && start && !abort;
    assign dbg_state    = state;

    prime_sieve_stepper #(
        .N_WIDTH    (N_WIDTH),
        .SQRT_WIDTH (SQRT_WIDTH)
    ) u_stepper (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .advance     (advance),
        .p           (p_q),
        .max_value   (max_q),
        .square_over (square_over),
        .mark_addr   (mark_addr),
        .last_write  (last_write)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            p_q    <= SQRT_WIDTH'(FIRST_PRIME);
            max_q  <= '0;
            sqrt_q <= '0;
        end else begin
            state <= next_state;
            if (accept_start) begin
                max_q  <= max_prime;
                sqrt_q <= sqrt_bound;
                p_q    <= SQRT_WIDTH'(FIRST_PRIME);
            end else if (!abort && next_base && (p_q != sqrt_q)) begin
                p_q <= p_q + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        ram_addr   = '0;
        ram_rden   = 1'b0;
        ram_wren   = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        next_base  = 1'b0;

        case (state)
            IDLE: begin
                if (accept_start) begin
                    next_state = (sqrt_bound < SQRT_WIDTH'(FIRST_PRIME)) ? DONE : CHECK;
                end
            end
            CHECK: begin
                ram_addr   = N_WIDTH'(p_q);
                ram_rden   = 1'b1;
                next_state = EVAL;
            end
            EVAL: begin
                // Composite base or square beyond the bound: nothing to mark.
                if (ram_rdata || square_over) begin
                    next_base = 1'b1;
                end else begin
                    load       = 1'b1;
                    next_state = MARK;
                end
            end
            MARK: begin
                ram_addr = mark_addr;
                ram_wren = 1'b1;
                advance  = 1'b1;
                if (last_write) begin
                    next_base = 1'b1;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (next_base) begin
            next_state = (p_q == sqrt_q) ? DONE : CHECK;
        end

        if (abort && (state != IDLE)) begin
            next_state = IDLE;
        end
    end

endmodule

// File: tb/tb_prime_sieve_engine.sv
module tb_prime_sieve_engine;
    import prime_sieve_pkg::*;

    localparam int NW    = 10;
    localparam int SW    = 6;
    localparam int DEPTH = 1 << NW;
    localparam int LIMIT = 4000;

    // ---------------- clock / reset ----------------
    logic          clock = 1'b0;
    logic          reset;
    logic          start, abort;
    logic [NW-1:0] max_prime;
    logic [SW-1:0] sqrt_bound;
    logic          busy, done, ram_rden, ram_rdata, ram_wren;
    logic [NW-1:0] ram_addr;
    logic [2:0]    dbg_state;

    always #5 clock = ~clock;

    prime_sieve_engine #(.N_WIDTH(NW), .SQRT_WIDTH(SW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .max_prime  (max_prime),
        .sqrt_bound (sqrt_bound),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_rden   (ram_rden),
        .ram_rdata  (ram_rdata),
        .ram_wren   (ram_wren),
        .dbg_state  (dbg_state)
    );

    // ---------------- external boolean RAM ----------------
    logic ram_mem   [DEPTH];
    logic model_mem [DEPTH];

    always @(posedge clock) begin
        if (ram_rden) ram_rdata <= ram_mem[ram_addr];
        if (ram_wren) ram_mem[ram_addr] = 1'b1;
    end

    task automatic clear_ram();
        for (int k = 0; k < DEPTH; k++) ram_mem[k] = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    logic [NW-1:0] exp_q[$];
    logic [NW-1:0] rd_q[$];
    int errors = 0;
    int checks = 0;
    int wr_count, rd_count;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            check("strobe_exclusive", 32'(ram_rden && ram_wren), 0);
            if (ram_wren) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0d, no write expected", ram_addr);
                end else begin
                    check("write_addr", 32'(ram_addr), 32'(exp_q.pop_front()));
                end
            end
            if (ram_rden) begin
                rd_count++;
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: addr %0d, no read expected", ram_addr);
                end else begin
                    check("read_addr", 32'(ram_addr), 32'(rd_q.pop_front()));
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Plain sieve arithmetic over a copy of the RAM: which bases are read,
    // which multiples get written in order, and how long the run takes.
    task automatic build_expect(input int mx, input int sq, output int n_wr, output int n_rd, output int done_c);
        int cyc;
        int step;
        for (int k = 0; k < DEPTH; k++) model_mem[k] = ram_mem[k];
        exp_q.delete();
        rd_q.delete();
        n_wr = 0; n_rd = 0; cyc = 0;
        for (int p = 2; p <= sq; p++) begin
            rd_q.push_back(NW'(p));
            n_rd++;
            cyc += 2;
            if (model_mem[p]) continue;
            if (p * p > mx) continue;
            step = p;
`ifdef PRIME_SIEVE_ODD_STEP_EN
            if (p > 2) step = 2 * p;
`endif
            for (int m = p * p; m <= mx; m += step) begin
                exp_q.push_back(NW'(m));
                model_mem[m] = 1'b1;
                n_wr++;
                cyc++;
            end
        end
        done_c = cyc + 1;
    endtask

    function automatic bit is_comp(input int k);
        if (k < 4) return 1'b0;
        for (int d = 2; d * d <= k; d++) if (k % d == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_ram_model(input string name);
        int mism = 0;
        for (int k = 0; k < DEPTH; k++) if (ram_mem[k] !== model_mem[k]) mism++;
        check(name, mism, 0);
    endtask

    task automatic check_ram_golden(input string name, input int mx);
        int mism = 0;
        for (int k = 0; k < DEPTH; k++)
            if (ram_mem[k] !== ((k <= mx) && is_comp(k))) mism++;
        check(name, mism, 0);
    endtask

    // ---------------- driver ----------------
    task automatic run_dut(input int mx, input int sq, output int done_c, output int busy_low);
        @(posedge clock); #1;
        max_prime = NW'(mx); sqrt_bound = SW'(sq); start = 1'b1;
        wr_count = 0; rd_count = 0;
        @(posedge clock); #1;
        start = 1'b0;
        // Inputs wander while busy; the latched values must be used.
        max_prime = NW'($urandom); sqrt_bound = SW'($urandom);
        done_c = -1; busy_low = 0;
        for (int c = 1; c <= LIMIT; c++) begin
            @(negedge clock);
            if (!busy) busy_low++;
            if (done) begin done_c = c; break; end
            @(posedge clock);
        end
        if (done_c < 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within %0d cycles", LIMIT);
        end
        @(negedge clock);
        check("busy_after_done", 32'(busy), 0);
        check("done_single_pulse", 32'(done), 0);
    endtask

    typedef struct {
        int mx;
        int sq;
        int exp_writes;
        int exp_reads;
        int exp_done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n_wr, n_rd, m_done, d_cyc, b_low, mx, sq;

        // ---- reset state ----
        reset = 1'b1; start = 1'b0; abort = 1'b0; max_prime = '0; sqrt_bound = '0;
        clear_ram();
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_rden", 32'(ram_rden), 0);
        check("reset_wren", 32'(ram_wren), 0);
        check("reset_addr", 32'(ram_addr), 0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;

        // ---- table-driven vectors ----
`ifdef PRIME_SIEVE_ODD_STEP_EN
        vecs[0] = '{30, 5, 19, 4, 28};
        vecs[5] = '{15, 3,  8, 2, 13};
`else
        vecs[0] = '{30, 5, 24, 4, 33};
        vecs[5] = '{15, 3,  9, 2, 14};
`endif
        vecs[1] = '{3,  2, 0, 1, 3};
        vecs[2] = '{10, 1, 0, 0, 1};
        vecs[3] = '{10, 0, 0, 0, 1};
        vecs[4] = '{8,  2, 3, 1, 6};

        foreach (vecs[i]) begin
            clear_ram();
            build_expect(vecs[i].mx, vecs[i].sq, n_wr, n_rd, m_done);
            run_dut(vecs[i].mx, vecs[i].sq, d_cyc, b_low);
            check($sformatf("vec%0d_writes", i), wr_count, vecs[i].exp_writes);
            check($sformatf("vec%0d_reads", i), rd_count, vecs[i].exp_reads);
            check($sformatf("vec%0d_done_cycle", i), d_cyc, vecs[i].exp_done);
            check($sformatf("vec%0d_busy_gaps", i), b_low, 0);
            check_ram_golden($sformatf("vec%0d_ram_golden", i), (vecs[i].sq >= 2) ? vecs[i].mx : -1);
        end

        // ---- overflow corner: full range ----
        clear_ram();
        build_expect(1023, 31, n_wr, n_rd, m_done);
        run_dut(1023, 31, d_cyc, b_low);
        check("ovf_done_cycle", d_cyc, m_done);
        check("ovf_writes", wr_count, n_wr);
        check("ovf_pending_writes", exp_q.size(), 0);
        check_ram_golden("ovf_ram_golden", 1023);
        for (int k = 0; k < 4; k++) check($sformatf("ovf_low_%0d", k), 32'(ram_mem[k]), 0);

        // ---- randomized runs against the model ----
        for (int r = 0; r < 8; r++) begin
            clear_ram();
            // sprinkle stale marks so skipped bases vary
            for (int k = 0; k < 6; k++) ram_mem[$urandom_range(0, DEPTH - 1)] = 1'b1;
            mx = $urandom_range(0, DEPTH - 1);
            sq = 0;
            while ((sq + 1) * (sq + 1) <= mx) sq++;
            if ($urandom_range(0, 3) == 0) sq = $urandom_range(0, 40);
            build_expect(mx, sq, n_wr, n_rd, m_done);
            run_dut(mx, sq, d_cyc, b_low);
            check($sformatf("rnd%0d_done_cycle", r), d_cyc, m_done);
            check($sformatf("rnd%0d_writes", r), wr_count, n_wr);
            check($sformatf("rnd%0d_reads", r), rd_count, n_rd);
            check_ram_model($sformatf("rnd%0d_ram", r));
        end

        // ---- abort during MARK for p=3 (cycle 20, second p=3 write) ----
        clear_ram();
        build_expect(30, 5, n_wr, n_rd, m_done);
        @(posedge clock); #1;
        max_prime = NW'(30); sqrt_bound = SW'(5); start = 1'b1;
        wr_count = 0; rd_count = 0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("abort_writes_issued", wr_count, 16);
        exp_q.delete();
        rd_q.delete();
        @(negedge clock);
        check("abort_busy", 32'(busy), 0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        check("abort_wren", 32'(ram_wren), 0);
        b_low = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (done || busy) b_low++;
        end
        check("abort_no_done", b_low, 0);
        build_expect(30, 5, n_wr, n_rd, m_done);
        run_dut(30, 5, d_cyc, b_low);
        check("abort_rerun_done_cycle", d_cyc, m_done);
        check_ram_golden("abort_rerun_ram", 30);

        // ---- asynchronous reset mid-MARK, start held high while busy ----
        clear_ram();
        build_expect(30, 5, n_wr, n_rd, m_done);
        @(posedge clock); #1;
        max_prime = NW'(30); sqrt_bound = SW'(5); start = 1'b1;
        wr_count = 0;
        @(posedge clock); #1;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_wren", 32'(ram_wren), 0);
        check("arst_rden", 32'(ram_rden), 0);
        check("arst_addr", 32'(ram_addr), 0);
        check("arst_state", 32'(dbg_state), 32'(IDLE));
        check("arst_writes_before", wr_count, 2);
        exp_q.delete();
        rd_q.delete();
        start = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        clear_ram();
        build_expect(8, 2, n_wr, n_rd, m_done);
        run_dut(8, 2, d_cyc, b_low);
        check("arst_rerun_done_cycle", d_cyc, 6);
        check_ram_golden("arst_rerun_ram", 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
